dense_engine_seq: RTL and testbench

Sequenced, parametrised successor to the parallel dense layer: `Engines` MAC lanes share one broadcast activation per beat. Each lane streams its own weight and accumulates over a runtime-programmable input length. After the last beat, each lane applies:
- rounding arithmetic right shift,
- per-lane bias add,
- saturation to N bits,
- optional ReLU.

The result vector is presented on a valid/ready output. The block sits between the activation/weight memory readers and the next layer's input buffer.

---
 rtl/dense_engine_seq_if.sv | 42 ++++
 rtl/dense_engine_seq.sv | 184 ++++++++++++++++++
 tb/tb_dense_engine_seq.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_engine_seq_if.sv
// ----------------------------------------------------------------------------
// dense_engine_seq_if
// Bundles the signals of dense_engine_seq apart from clock and reset:
//   vector control : start_i, len_i, shift_i, relu_i, bias_i -> busy_o
//   input stream   : in_valid_i, act_i, weight_i -> in_ready_o
//   output stream  : out_valid_o, dense_o, sat_o <- out_ready_i
// master = the upstream/downstream side driving the engine, slave = the engine.
// Lane k of the flat vectors bias_i, weight_i and dense_o sits at [k*N +: N].
// ----------------------------------------------------------------------------
interface dense_engine_seq_if #(
    parameter int N       = 16,
    parameter int Engines = 8,
    parameter int MaxLen  = 1024,
    parameter int LenW    = $clog2(MaxLen + 1)
);
    logic                   start_i;
    logic [LenW-1:0]        len_i;
    logic [5:0]             shift_i;
    logic                   relu_i;
    logic [Engines*N-1:0]   bias_i;
    logic                   busy_o;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [N-1:0]           act_i;
    logic [Engines*N-1:0]   weight_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [Engines*N-1:0]   dense_o;
    logic [Engines-1:0]     sat_o;

    modport master (
        output start_i, len_i, shift_i, relu_i, bias_i,
        output in_valid_i, act_i, weight_i, out_ready_i,
        input  busy_o, in_ready_o, out_valid_o, dense_o, sat_o
    );

    modport slave (
        input  start_i, len_i, shift_i, relu_i, bias_i,
        input  in_valid_i, act_i, weight_i, out_ready_i,
        output busy_o, in_ready_o, out_valid_o, dense_o, sat_o
    );
endinterface

// File: rtl/dense_engine_seq.sv
// ----------------------------------------------------------------------------
// dense_engine_seq
// Sequenced dense layer: Engines MAC lanes share one broadcast activation per
// beat, each with its own weight stream. After len beats every lane applies a
// rounding arithmetic right shift, adds its bias, saturates to N bits and
// optionally applies ReLU. The result vector is held on a valid/ready output.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-low reset
//   bus    : dense_engine_seq_if.slave (control, input stream, output stream)
// ----------------------------------------------------------------------------
module dense_engine_seq #(
    parameter int N       = 16,
    parameter int Engines = 8,
    parameter int MaxLen  = 1024,
    parameter int LenW    = $clog2(MaxLen + 1),
    parameter int AccW    = 2 * N + $clog2(MaxLen)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dense_engine_seq_if.slave bus
);
    localparam int PW   = 2 * N;     // full-precision product width
    localparam int RndW = AccW + 1;  // room for the rounding increment
    localparam int SumW = AccW + 2;  // room for the bias add

    localparam logic signed [SumW-1:0] SatMax = {{(SumW - N + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [SumW-1:0] SatMin = {{(SumW - N + 1){1'b1}}, {(N - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, FINISH, OUT} state_t;

    state_t                 state;
    logic [LenW-1:0]        len_q;
    logic [LenW-1:0]        cnt;
    logic [5:0]             shift_q;
    logic                   relu_q;
    logic [Engines*N-1:0]   bias_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   busy_q;

    logic signed [PW-1:0]   prod_p0 [Engines];
    logic signed [AccW-1:0] acc_p0  [Engines];
    logic [Engines*N-1:0]   dense_p1;
    logic [Engines-1:0]     sat_p1;

    logic [LenW-1:0]        len_eff;
    logic [5:0]             shift_eff;
    logic signed [SumW-1:0] sum_c;
    logic [N:0]             res_c;
    logic [Engines*N-1:0]   fin_dense;
    logic [Engines-1:0]     fin_sat;

    // (a + 2^(sh-1)) >>> sh, computed one bit wider so the increment never wraps
    function automatic logic signed [RndW-1:0] round_shift(
        input logic signed [AccW-1:0] a,
        input logic [5:0]             sh
    );
        logic signed [RndW-1:0] ext;
        logic signed [RndW-1:0] half;
        ext  = RndW'(a);
        half = '0;
        if (sh != 6'd0) half = RndW'(1) << (sh - 6'd1);
        return (ext + half) >>> sh;
    endfunction

    // Returns {clipped, value}; ReLU is applied after the clip flag is decided
    function automatic logic [N:0] saturate(
        input logic signed [SumW-1:0] s,
        input logic                   relu
    );
        logic [N-1:0] v;
        logic         clip;
        clip = 1'b0;
        if (s > SatMax) begin
            v    = SatMax[N-1:0];
            clip = 1'b1;
        end else if (s < SatMin) begin
            v    = SatMin[N-1:0];
            clip = 1'b1;
        end else begin
            v = s[N-1:0];
        end
        if (relu && v[N-1]) v = '0;
        return {clip, v};
    endfunction

    assign len_eff   = (bus.len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : bus.len_i;
    assign shift_eff = (int'(bus.shift_i) >= AccW) ? 6'(AccW - 1) : bus.shift_i;

    // ---- stage p0: per-lane products of the broadcast activation ----
    always_comb begin
        for (int k = 0; k < Engines; k++) begin
            prod_p0[k] = PW'($signed(bus.act_i)) * PW'($signed(bus.weight_i[k*N +: N]));
        end
    end

    // ---- stage p1: post-processing of the finished accumulators ----
    always_comb begin
        fin_dense = '0;
        fin_sat   = '0;
        sum_c     = '0;
        res_c     = '0;
        for (int k = 0; k < Engines; k++) begin
            sum_c = SumW'(round_shift(acc_p0[k], shift_q))
                  + SumW'($signed(bias_q[k*N +: N]));
            res_c = saturate(sum_c, relu_q);
            fin_dense[k*N +: N] = res_c[N-1:0];
            fin_sat[k]          = res_c[N];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            len_q       <= '0;
            cnt         <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            bias_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            dense_p1    <= '0;
            sat_p1      <= '0;
            for (int k = 0; k < Engines; k++) acc_p0[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        len_q   <= len_eff;
                        shift_q <= shift_eff;
                        relu_q  <= bus.relu_i;
                        bias_q  <= bus.bias_i;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        for (int k = 0; k < Engines; k++) acc_p0[k] <= '0;
                        if (len_eff != '0) begin
                            state      <= ACCUM;
                            in_ready_q <= 1'b1;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                ACCUM: begin
                    // in_ready_q is high throughout ACCUM, so valid alone is the handshake
                    if (bus.in_valid_i) begin
                        for (int k = 0; k < Engines; k++) begin
                            acc_p0[k] <= acc_p0[k] + AccW'(prod_p0[k]);
                        end
                        cnt <= cnt + LenW'(1);
                        if (cnt + LenW'(1) == len_q) begin
                            state      <= FINISH;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                FINISH: begin
                    dense_p1    <= fin_dense;
                    sat_p1      <= fin_sat;
                    out_valid_q <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    // start_i is deliberately not looked at here
                    if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.dense_o     = dense_p1;
    assign bus.sat_o       = sat_p1;

endmodule

// File: tb/tb_dense_engine_seq.sv
// ----------------------------------------------------------------------------
// tb_dense_engine_seq
// Randomised and directed vectors for dense_engine_seq. The driver pushes the
// reference-model result for every vector it issues; a negedge monitor pops
// and compares whenever out_valid_o rises and keeps comparing while it is held.
// ----------------------------------------------------------------------------
module tb_dense_engine_seq;
    localparam int N    = 16;
    localparam int E    = 4;
    localparam int ML   = 1024;
    localparam int LenW = $clog2(ML + 1);
    localparam int AccW = 2 * N + $clog2(ML);
    localparam longint MaxV = (longint'(1) << (N - 1)) - 1;
    localparam longint MinV = -(longint'(1) << (N - 1));

    typedef struct {
        logic [E*N-1:0] dense;
        logic [E-1:0]   sat;
    } exp_t;

    logic clk_i;
    logic rst_i;

    dense_engine_seq_if #(.N(N), .Engines(E), .MaxLen(ML)) bus ();

    dense_engine_seq #(.N(N), .Engines(E), .MaxLen(ML)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t cur;
    bit   have_cur = 0;
    bit   prev_v   = 0;

    int act_a [ML];
    int wgt_a [ML][E];
    int bias_a[E];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input longint got, input longint req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    function automatic int rnd16();
        logic signed [N-1:0] v;
        v = N'($urandom);
        return int'(v);
    endfunction

    // Reference: sum of products in wide integers, then the output rules
    function automatic exp_t model(input int len, input int sh, input bit relu);
        exp_t   e;
        longint acc;
        longint v;
        int     l;
        int     s;
        l = (len > ML) ? ML : len;
        s = (sh >= AccW) ? AccW - 1 : sh;
        e.dense = '0;
        e.sat   = '0;
        for (int k = 0; k < E; k++) begin
            acc = 0;
            for (int i = 0; i < l; i++) acc += longint'(act_a[i]) * longint'(wgt_a[i][k]);
            if (s > 0) acc = (acc + (longint'(1) << (s - 1))) >>> s;
            v = acc + longint'(bias_a[k]);
            if (v > MaxV) begin
                v = MaxV;
                e.sat[k] = 1'b1;
            end else if (v < MinV) begin
                v = MinV;
                e.sat[k] = 1'b1;
            end
            if (relu && v < 0) v = 0;
            e.dense[k*N +: N] = v[N-1:0];
        end
        return e;
    endfunction

    task automatic drive_beat(input int i);
        bus.act_i = act_a[i][N-1:0];
        for (int k = 0; k < E; k++) bus.weight_i[k*N +: N] = wgt_a[i][k][N-1:0];
    endtask

    task automatic drive_junk();
        bus.act_i    = N'($urandom);
        bus.weight_i = {$urandom, $urandom};
    endtask

    task automatic run_vec(input int len, input int sh, input bit relu,
                           input bit stall, input int hold);
        int l;
        int i;
        int budget;
        bit hs;
        l = (len > ML) ? ML : len;
        sb.push_back(model(len, sh, relu));
        bus.len_i   = LenW'(len);
        bus.shift_i = 6'(sh);
        bus.relu_i  = relu;
        for (int k = 0; k < E; k++) bus.bias_i[k*N +: N] = bias_a[k][N-1:0];
        bus.out_ready_i = (hold == 0);
        bus.start_i = 1'b1;
        @(posedge clk_i); #1;
        bus.start_i = 1'b0;
        // the engine must have latched its settings; scramble them
        bus.len_i   = LenW'($urandom);
        bus.shift_i = 6'($urandom);
        bus.relu_i  = ~relu;
        bus.bias_i  = {$urandom, $urandom};
        chk("busy_after_start", bus.busy_o, 1);
        chk("in_ready_after_start", bus.in_ready_o, (l > 0) ? 1 : 0);
        i = 0;
        budget = 0;
        while (i < l && budget < 20000) begin
            if (stall && $urandom_range(0, 1) == 0) begin
                bus.in_valid_i = 1'b0;
                drive_junk();
            end else begin
                bus.in_valid_i = 1'b1;
                drive_beat(i);
            end
            hs = bus.in_valid_i && bus.in_ready_o;
            @(posedge clk_i); #1;
            if (hs) i++;
            budget++;
        end
        bus.in_valid_i = 1'b0;
        drive_junk();
        chk("beats_accepted", i, l);
        chk("no_valid_in_finish", bus.out_valid_o, 0);
        @(posedge clk_i); #1;
        chk("valid_after_finish", bus.out_valid_o, 1);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                bus.start_i = 1'b1;
                @(posedge clk_i); #1;
                chk("valid_held", bus.out_valid_o, 1);
                chk("busy_held", bus.busy_o, 1);
            end
            bus.out_ready_i = 1'b1;
            @(posedge clk_i); #1;
            bus.start_i = 1'b0;
        end else begin
            @(posedge clk_i); #1;
        end
        chk("valid_dropped", bus.out_valid_o, 0);
        chk("idle_after_out", bus.busy_o, 0);
    endtask

    task automatic fill(input int len);
        for (int i = 0; i < len; i++) begin
            act_a[i] = rnd16();
            for (int k = 0; k < E; k++) wgt_a[i][k] = rnd16();
        end
    endtask

    task automatic fill_bias_rand();
        for (int k = 0; k < E; k++) bias_a[k] = rnd16();
    endtask

    // Scoreboard monitor
    always @(negedge clk_i) begin
        if (!rst_i) begin
            prev_v   = 1'b0;
            have_cur = 1'b0;
        end else begin
            if (bus.out_valid_o && !prev_v) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got a result, required none queued");
                    have_cur = 1'b0;
                end else begin
                    cur      = sb.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (bus.out_valid_o && have_cur) begin
                for (int k = 0; k < E; k++) begin
                    chk($sformatf("dense_lane%0d", k),
                        $signed(bus.dense_o[k*N +: N]), $signed(cur.dense[k*N +: N]));
                    chk($sformatf("sat_lane%0d", k), bus.sat_o[k], cur.sat[k]);
                end
            end
            prev_v = bus.out_valid_o;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        rst_i = 1'b0;
        bus.start_i = 1'b0;
        bus.len_i = '0;
        bus.shift_i = '0;
        bus.relu_i = 1'b0;
        bus.bias_i = '0;
        bus.in_valid_i = 1'b0;
        bus.act_i = '0;
        bus.weight_i = '0;
        bus.out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_in_ready", bus.in_ready_o, 0);
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_dense", bus.dense_o, 0);
        chk("rst_sat", bus.sat_o, 0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Basic: acts 1,2,3, lane k weights k+1 -> 6(k+1)
        for (int i = 0; i < 3; i++) begin
            act_a[i] = i + 1;
            for (int k = 0; k < E; k++) wgt_a[i][k] = k + 1;
        end
        for (int k = 0; k < E; k++) bias_a[k] = 0;
        run_vec(3, 0, 0, 0, 0);

        // Rounding: (15+2)>>>2 = 4, (-15+2)>>>2 = -4
        act_a[0] = 5;
        for (int k = 0; k < E; k++) wgt_a[0][k] = 3;
        run_vec(1, 2, 0, 0, 0);
        act_a[0] = -5;
        run_vec(1, 2, 0, 0, 0);

        // Saturation and ReLU
        for (int i = 0; i < 2; i++) begin
            act_a[i] = 32767;
            for (int k = 0; k < E; k++) wgt_a[i][k] = 32767;
        end
        run_vec(2, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) for (int k = 0; k < E; k++) wgt_a[i][k] = -32767;
        run_vec(2, 0, 0, 0, 0);
        run_vec(2, 0, 1, 0, 0);

        // Stall + backpressure, then the same data without stalls
        fill(8);
        fill_bias_rand();
        run_vec(8, 3, 0, 1, 5);
        run_vec(8, 3, 0, 0, 0);

        // len=0: result is sat(bias)
        bias_a[0] = -7; bias_a[1] = -7; bias_a[2] = 32767; bias_a[3] = -32768;
        run_vec(0, 0, 0, 0, 0);
        run_vec(0, 5, 1, 0, 2);

        // len=MaxLen with extreme operands: 2^40 must not wrap
        for (int i = 0; i < ML; i++) begin
            act_a[i] = -32768;
            for (int k = 0; k < E; k++) wgt_a[i][k] = -32768;
        end
        for (int k = 0; k < E; k++) bias_a[k] = 0;
        run_vec(ML, 0, 0, 0, 0);
        run_vec(ML, 63, 0, 0, 0);   // shift clamps to AccW-1 -> result 1

        // Over-long len clamps to MaxLen
        fill(ML);
        fill_bias_rand();
        run_vec(2000, 12, 0, 0, 0);

        // Reset during beat 2 of 4
        fill(4);
        bus.len_i = LenW'(4);
        bus.shift_i = '0;
        bus.relu_i = 1'b0;
        bus.start_i = 1'b1;
        @(posedge clk_i); #1;
        bus.start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid_i = 1'b1;
            drive_beat(i);
            @(posedge clk_i); #1;
        end
        drive_beat(2);
        #2 rst_i = 1'b0;
        #1;
        chk("abort_busy", bus.busy_o, 0);
        chk("abort_in_ready", bus.in_ready_o, 0);
        chk("abort_out_valid", bus.out_valid_o, 0);
        chk("abort_dense", bus.dense_o, 0);
        bus.in_valid_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        run_vec(4, 0, 0, 0, 0);

        // Random vectors
        for (int t = 0; t < 24; t++) begin
            int len;
            int sh;
            len = $urandom_range(0, 12);
            sh  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 20);
            fill(len);
            fill_bias_rand();
            run_vec(len, sh, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
        end

        w = 0;
        while (sb.size() > 0 && w < 100) begin
            @(posedge clk_i);
            w++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        repeat (2) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
